// File: rtl/lane_deskew.sv
// lane_deskew: receive-side two-lane deskew buffer (clk_f domain).
//
// Each lane locks to an alignment marker word; the non-marker words that
// follow are buffered in a per-lane circular FIFO. Pairs are released in
// lockstep, so lane_0 word k always leaves together with lane_1 word k,
// despite up to DEPTH-1 cycles of inter-lane skew and independent valid gaps.
//
// Ports:
//   clk_f      in   sole clock, rising edge
//   reset      in   synchronous, active-high
//   lane_0/1   in   received lane words (DATA_WIDTH)
//   valid_0/1  in   lane word qualifiers
//   lane_0_out out  deskewed lane 0 word (holds when no pair is released)
//   lane_1_out out  deskewed lane 1 word (holds when no pair is released)
//   valid_out  out  a matched pair is on lane_*_out this cycle
//   aligned    out  high while in the ALIGNED state
//   skew_err   out  one-cycle pulse on lock timeout or FIFO overflow
//
// DEPTH must be at least 2.
module lane_deskew #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 4,
    parameter logic [DATA_WIDTH-1:0] ALIGN_WORD = 32'hBCBC_BCBC
) (
    input  logic                  clk_f,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] lane_0,
    input  logic                  valid_0,
    input  logic [DATA_WIDTH-1:0] lane_1,
    input  logic                  valid_1,
    output logic [DATA_WIDTH-1:0] lane_0_out,
    output logic [DATA_WIDTH-1:0] lane_1_out,
    output logic                  valid_out,
    output logic                  aligned,
    output logic                  skew_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

    typedef enum logic [1:0] {SEARCH, LOCKING, ALIGNED} state_t;

    state_t                         state_q, state_d;
    logic [1:0]                     armed_q, armed_d;
    logic [CW-1:0]                  cnt_q, cnt_d;
    logic [1:0][PW-1:0]             rp_q, wp_q;
    logic [1:0][CW-1:0]             occ_q;
    logic [DATA_WIDTH-1:0]          mem_q [2][DEPTH];
    logic [1:0][DATA_WIDTH-1:0]     out_q;
    logic                           valid_q, aligned_q, skew_err_q;

    logic [1:0][DATA_WIDTH-1:0]     lane_in;
    logic [1:0]                     mark, push, full, empty;
    logic                           pop, late_mark, timeout, overflow, err;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign lane_in = {lane_1, lane_0};

    always_comb begin
        mark[0] = valid_0 && (lane_0 == ALIGN_WORD);
        mark[1] = valid_1 && (lane_1 == ALIGN_WORD);
        // Markers are never stored; only armed lanes accept data.
        push[0] = armed_q[0] && valid_0 && !mark[0];
        push[1] = armed_q[1] && valid_1 && !mark[1];
        for (int l = 0; l < 2; l++) begin
            full[l]  = (occ_q[l] == DEPTH_C);
            empty[l] = (occ_q[l] == '0);
        end
    end

    // Pop decision uses pre-push occupancy, so a word needs one edge in
    // the FIFO before it can be released.
    assign pop       = (state_q == ALIGNED) && !empty[0] && !empty[1];
    assign late_mark = (mark[0] && !armed_q[0]) || (mark[1] && !armed_q[1]);
    assign timeout   = (state_q == LOCKING) && (cnt_q >= DEPTH_C);
    assign overflow  = (state_q != SEARCH) && !pop &&
                       ((push[0] && full[0]) || (push[1] && full[1]));
    assign err       = timeout || overflow;

    always_comb begin
        state_d = state_q;
        armed_d = armed_q;
        cnt_d   = cnt_q;
        case (state_q)
            SEARCH: begin
                if (mark[0] && mark[1]) begin
                    state_d = ALIGNED;
                    armed_d = 2'b11;
                end else if (mark[0] || mark[1]) begin
                    state_d = LOCKING;
                    armed_d = mark;
                    cnt_d   = CW'(1);
                end
            end
            LOCKING: begin
                // Repeat markers on the armed lane don't count as late_mark,
                // so they cannot restart the skew window.
                cnt_d = cnt_q + 1'b1;
                if (late_mark && (cnt_q < DEPTH_C)) begin
                    state_d = ALIGNED;
                    armed_d = 2'b11;
                end
            end
            default: ;
        endcase
        if (err) begin
            state_d = SEARCH;
            armed_d = 2'b00;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk_f) begin
        if (reset) begin
            state_q    <= SEARCH;
            armed_q    <= 2'b00;
            cnt_q      <= '0;
            rp_q       <= '0;
            wp_q       <= '0;
            occ_q      <= '0;
            out_q      <= '0;
            valid_q    <= 1'b0;
            aligned_q  <= 1'b0;
            skew_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            armed_q    <= armed_d;
            cnt_q      <= cnt_d;
            aligned_q  <= (state_d == ALIGNED);
            skew_err_q <= err;
            valid_q    <= pop && !err;
            if (err) begin
                rp_q  <= '0;
                wp_q  <= '0;
                occ_q <= '0;
            end else begin
                for (int l = 0; l < 2; l++) begin
                    if (pop) begin
                        out_q[l] <= mem_q[l][rp_q[l]];
                        rp_q[l]  <= ptr_inc(rp_q[l]);
                    end
                    if (push[l])
                        wp_q[l] <= ptr_inc(wp_q[l]);
                    occ_q[l] <= occ_q[l] + CW'(push[l]) - CW'(pop);
                end
            end
        end
    end

    // Storage needs no reset; pointers and occupancy define what is valid.
    always_ff @(posedge clk_f) begin
        for (int l = 0; l < 2; l++)
            if (push[l])
                mem_q[l][wp_q[l]] <= lane_in[l];
    end

    assign lane_0_out = out_q[0];
    assign lane_1_out = out_q[1];
    assign valid_out  = valid_q;
    assign aligned    = aligned_q;
    assign skew_err   = skew_err_q;

endmodule

// File: doc/lane_deskew.md
Name: lane_deskew

Overview:
- Receive-side two-lane deskew buffer. Sits between the two PHY lane inputs and the byte un-striping block, in the clk_f domain.
- Each lane is locked to an alignment marker word. Words arriving after the marker are buffered in a per-lane FIFO.
- Words are released in lockstep, so un-striping always sees lane_0 word k paired with lane_1 word k, despite inter-lane skew of up to DEPTH-1 cycles and independent valid gaps.

Parameters:
DATA_WIDTH, 32, lane word width
DEPTH, 4, per-lane FIFO entries; also the skew limit (tolerated skew is DEPTH-1 cycles)
ALIGN_WORD, 32'hBCBC_BCBC, alignment marker value

Ports:
clk_f  input  1  sole clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
lane_0  input  DATA_WIDTH  lane 0 received word
valid_0  input  1  lane_0 qualifier
lane_1  input  DATA_WIDTH  lane 1 received word
valid_1  input  1  lane_1 qualifier
lane_0_out  output  DATA_WIDTH  deskewed lane 0 word
lane_1_out  output  DATA_WIDTH  deskewed lane 1 word
valid_out  output  1  both outputs carry a matched pair this cycle
aligned  output  1  high while in ALIGNED state
skew_err  output  1  one-cycle pulse on lock failure or overflow

Behaviour:
- Clocking/reset: one clock, clk_f; reset synchronous, active-high. While reset is high at an edge:
  - state -> SEARCH; both FIFOs flushed; arm flags and skew counter cleared.
  - lane_0_out = lane_1_out = 0; valid_out = aligned = skew_err = 0.
  - Reset mid-operation discards all buffered words.
- Marker: a word is a marker when valid_i=1 and lane_i==ALIGN_WORD. Markers are never written to a FIFO or forwarded, in any state.
- Arming:
  - A marker on lane i sets armed_i.
  - Once armed, every non-marker word with valid_i=1 is pushed into FIFO_i. valid_i=0 pushes nothing.
  - Words arriving before a lane is armed are discarded.
- State SEARCH:
  - Neither lane armed.
  - Marker on exactly one lane -> LOCKING, with skew counter loaded to 1.
  - Markers on both lanes in the same cycle -> ALIGNED directly.
- State LOCKING:
  - One lane armed; its FIFO fills. Counter increments each edge.
  - Marker on the unarmed lane at an edge where counter<DEPTH -> ALIGNED.
  - Counter==DEPTH with no such marker -> skew_err=1 for one cycle, flush, disarm, -> SEARCH.
  - Further markers on the armed lane are dropped and do not restart the counter.
- State ALIGNED:
  - Pop rule: pop one entry from each FIFO when both are non-empty at the edge (pre-push occupancy).
  - The popped pair is registered to lane_0_out/lane_1_out with valid_out=1.
  - When no pop occurs, valid_out=0 and the data outputs hold their last value.
  - Latency: a word pushed at edge k is output at edge k+1 at the earliest; valid_out is then visible until edge k+2.
  - Markers in ALIGNED are dropped; there is no realignment.
- Overflow: push to a full FIFO in the same cycle as no pop, in LOCKING or ALIGNED, raises skew_err (one cycle), flushes, disarms, -> SEARCH. Push and pop in the same cycle on a full FIFO is legal.
- Error-cycle outputs: on an error edge, valid_out=0. aligned drops on the same edge.
- FIFO: circular, read/write pointers of $clog2(DEPTH) bits with wrap-around, plus an occupancy count 0..DEPTH.
- aligned is registered: aligned=1 exactly when state==ALIGNED.

Test Plan:
- Zero skew, DEPTH=4:
  - Stimulus: ALIGN_WORD on both lanes at edge t. Then lane_0 = FFFF_FFFF, DDDD_DDDD and lane_1 = EEEE_EEEE, CCCC_CCCC at t+1, t+2.
  - Required: aligned=1 after t. Pairs (FFFF_FFFF, EEEE_EEEE) after t+2 and (DDDD_DDDD, CCCC_CCCC) after t+3, valid_out=1 for both. Words sent before t never appear.
- Skew 2:
  - Stimulus: lane_1 stream delayed 2 cycles relative to lane_0.
  - Required: skew_err never asserts; aligned=1 after lane_1 marker; pairing identical to the zero-skew case, shifted 2 cycles.
- Skew 4 (=DEPTH):
  - Stimulus: lane_1 marker arrives 4 cycles after lane_0 marker.
  - Required: skew_err pulses for 1 cycle at the 4th edge; aligned=0; valid_out stays 0.
  - Follow-up: simultaneous markers then relock to ALIGNED.
- Valid gap:
  - Stimulus: in ALIGNED, valid_0=0 for one cycle while lane_1 streams.
  - Required: valid_out=0 for one cycle; subsequent pairs still matched by index; no skew_err.
- Overflow:
  - Stimulus: in ALIGNED with empty FIFOs, valid_1 held low 5 cycles while lane_0 streams.
  - Required: the 5th lane_0 push raises skew_err; FIFOs flush; state SEARCH, aligned=0.
- Reset mid-stream:
  - Stimulus: assert reset for 1 cycle in ALIGNED with 2 entries buffered.
  - Required: after that edge, outputs = 0, valid_out=0, aligned=0. Buffered words never emerge after re-lock.
